// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared edge-mode encodings and sizing helper for the input conditioner.
`default_nettype none

package input_cond_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // A window of one cycle still needs a one-bit counter.
  function automatic int debounce_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_cond_channel.sv
// input_cond_channel: synchroniser, debouncer, edge pulse, sticky flag and
// saturating event counter for a single input.
`default_nettype none

module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_in,
  input  logic [1:0]             edge_mode,
  input  logic                   clear,
  output logic                   data_debounced,
  output logic                   pulse,
  output logic                   event_flag,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic                   flag_next
);

  localparam int                   CNT_W     = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   deb_d;
  logic                   update;
  logic                   dir_match;
  logic                   pulse_d;
  logic [COUNT_WIDTH-1:0] count_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
    end
  end

  // Any agreement with the accepted level restarts the stability window.
  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = data_debounced;
    update = 1'b0;
    if (sync_out == data_debounced) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d  = sync_out;
      cnt_d  = '0;
      update = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The direction of an accepted change is the new level itself.
  always_comb begin
    dir_match = 1'b0;
    case (edge_mode)
      EDGE_NONE: dir_match = 1'b0;
      EDGE_RISE: dir_match = sync_out;
      EDGE_FALL: dir_match = ~sync_out;
      EDGE_BOTH: dir_match = 1'b1;
      default:   dir_match = 1'b0;
    endcase
  end

  assign pulse_d   = update & dir_match;
  assign flag_next = pulse | (event_flag & ~clear);

  // A pulse coinciding with clear is counted as the first event after clear.
  always_comb begin
    count_d = event_count;
    if (clear) begin
      count_d = COUNT_WIDTH'(pulse);
    end else if (pulse && (event_count != COUNT_MAX)) begin
      count_d = event_count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      data_debounced <= 1'b0;
      pulse          <= 1'b0;
      event_flag     <= 1'b0;
      event_count    <= '0;
    end else begin
      cnt_q          <= cnt_d;
      data_debounced <= deb_d;
      pulse          <= pulse_d;
      event_flag     <= flag_next;
      event_count    <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// input_conditioner: CHANNELS independent conditioned inputs with a combined
// any-event indication aligned to the per-channel flags.
`default_nettype none

module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             data_in,
  input  logic [2*CHANNELS-1:0]           edge_mode,
  input  logic [CHANNELS-1:0]             clear,
  output logic [CHANNELS-1:0]             data_debounced,
  output logic [CHANNELS-1:0]             pulse,
  output logic [CHANNELS-1:0]             event_flag,
  output logic [CHANNELS*COUNT_WIDTH-1:0] event_count,
  output logic                            any_event
);

  logic [CHANNELS-1:0] flag_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_cond_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .COUNT_WIDTH    (COUNT_WIDTH)
    ) u_channel (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in[i]),
      .edge_mode     (edge_mode[2*i +: 2]),
      .clear         (clear[i]),
      .data_debounced(data_debounced[i]),
      .pulse         (pulse[i]),
      .event_flag    (event_flag[i]),
      .event_count   (event_count[i*COUNT_WIDTH +: COUNT_WIDTH]),
      .flag_next     (flag_next[i])
    );
  end

  // Reducing the next-state flags keeps any_event in step with event_flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_event <= 1'b0;
    end else begin
      any_event <= |flag_next;
    end
  end

endmodule

`default_nettype wire

// File: doc/input_conditioner.md
# input_conditioner

- Parametrised, multi-channel successor to the single-bit debounce / one-shot / sync chain.
- Per channel: synchronises an asynchronous input, debounces it with a programmable stability window and produces a one-cycle pulse on rising, falling or both edges, selected per channel at run time.
- Per channel: keeps a sticky event flag and a saturating event counter, both cleared by a write-1-to-clear strobe.
- Sits between board-level switches/strobes and the instruction/control logic.

## Interface
- CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: synchroniser depth in flops (>=2).
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a new level (>=1); counter width is $clog2(DEBOUNCE_CYCLES), minimum 1.
- COUNT_WIDTH, 8: width of each per-channel event counter (>=1).
- clk  input  1  single system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  CHANNELS  raw asynchronous inputs.
- edge_mode  input  2*CHANNELS  per-channel pulse select; bits [2i+1:2i] for channel i; quasi-static.
- clear  input  CHANNELS  write-1-to-clear strobe for flag and counter of channel i.
- data_debounced  output  CHANNELS  debounced level.
- pulse  output  CHANNELS  one-cycle edge pulse.
- event_flag  output  CHANNELS  sticky "pulse occurred" flag.
- event_count  output  CHANNELS*COUNT_WIDTH  saturating pulse count; bits [i*COUNT_WIDTH +: COUNT_WIDTH] for channel i.
- any_event  output  1  OR of all event_flag bits.

## Operation
- Reset (reset==0): all sync flops, data_debounced, debounce counters, pulse, event_flag, event_count and any_event go to 0 immediately.
- Sync: data_in[i] shifts through SYNC_STAGES flops; the last stage is sync_out[i].
- Debounce, per channel, each edge:
  - sync_out == data_debounced: counter <= 0.
  - Mismatch and counter == DEBOUNCE_CYCLES-1: data_debounced <= sync_out, counter <= 0.
  - Otherwise: counter++.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES edges leaves data_debounced unchanged.
- edge_mode encoding: 00 none, 01 rising, 10 falling, 11 both.
- Pulse: registered; asserted for exactly one cycle, coincident with a data_debounced update, when the update direction matches edge_mode. It is 0 in all other cycles.
- event_flag: set by pulse, cleared by clear; simultaneous pulse and clear leaves the flag set.
- event_count: +1 per pulse and saturates at 2^COUNT_WIDTH-1. On clear it loads 0, or 1 if pulse fires in the same cycle.
- any_event: registered OR of the next-state event_flag values, so it is aligned with event_flag.
- Channels are fully independent; a clear on one channel never affects another.

## Timing
- Level-change latency:
  - Edge 0 is the first edge sampling the new, stable level.
  - data_debounced and pulse update on edge SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges inclusive.
  - Example: S=2, D=4 gives the update on edge 5.
- event_flag and event_count update one edge after pulse.
- clear takes effect on the next edge.
- Changing edge_mode affects only later updates; no retroactive pulse.
- Reset release with an input held high: sync refills from 0, and a rising pulse follows S+D edges after the first post-release edge.
- Reset mid-debounce discards the partial count.

## Structure
- Package input_cond_pkg holds:
  - Constants EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11.
  - A function returning the debounce counter width (max($clog2(D),1)).
- Sub-module input_cond_channel: synchroniser, debounce, edge/pulse logic, flag and counter for one channel.
- The top instantiates input_cond_channel CHANNELS times in a generate loop and reduces any_event.

## Test plan
Parameters: CHANNELS=4, S=2, D=4, COUNT_WIDTH=4.

- Reset: hold reset=0 with data_in=4'hF -> all outputs 0. Release -> ch0–3 data_debounced=1 and pulse on edge 5 (modes=11); event_count=1 one edge later.
- Glitch reject: ch0 mode 01, data_in[0] high for 3 cycles, then low -> no data_debounced change, no pulse, count 0. Held high 4 cycles -> pulse on edge 5.
- Mode select: ch1=01, ch2=10, ch3=00. Toggle all inputs 0->1->0 with 10-cycle holds -> ch1 pulses once on rise, ch2 once on fall, ch3 never; data_debounced follows the input on all three.
- Saturation: 20 rising edges on ch0 -> event_count[0]=15, event_flag[0]=1, any_event=1.
- Clear collision: clear[0] asserted in the same cycle as a ch0 pulse -> event_flag[0] stays 1, event_count[0]=1. Clear alone -> 0, 0, any_event=0 when no other flags are set.
- Mid-operation reset: assert reset 2 cycles into a 4-cycle debounce window -> all outputs 0 asynchronously. After release the full S+D latency is re-measured from scratch.
